uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arb_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared types and constants for the UART TX arbiter.
//   state_t  - arbiter FSM state encoding
//   CH_TAG   - upper nibble of the per-grant channel tag byte
//   clog2w() - index/counter width helper, never returns less than 1
package uart_tx_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    RD    = 3'd2,
    LATCH = 3'd3,
    TX    = 3'd4,
    NEXT  = 3'd5
  } state_t;

  localparam logic [7:0] CH_TAG = 8'hA0;

  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req     - request vector, one bit per channel
//   ptr     - channel with highest priority this round
//   winner  - first requesting channel scanning upward from ptr (wraps)
//   any_req - at least one request present
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [clog2w(NUM_CH)-1:0] ptr,
  output logic [clog2w(NUM_CH)-1:0] winner,
  output logic                      any_req
);

  localparam int W = clog2w(NUM_CH);

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_CH]) begin
        winner  = W'((int'(ptr) + i) % NUM_CH);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_CH byte FIFOs.
// Performs the FIFO read for the granted channel, holds the byte on TX_Data
// and keeps TX_En_Sig high until TX_Done_Sig, up to MAX_BURST bytes per grant.
//
// Ports:
//   CLK, RST        - clock, synchronous active-high reset
//   Ch_En           - per-channel arbitration enable
//   Empty_Sig       - per-channel FIFO empty flag
//   FIFO_Read_Data  - channel n byte on [8n+7:8n], valid the cycle after Read_Req_Sig
//   Read_Req_Sig    - one-hot single-cycle FIFO read pulse
//   TX_Done_Sig     - frame-complete pulse from the UART
//   TX_Data         - byte to transmit
//   TX_En_Sig       - transmit request level
//   Grant_Ch        - current / last granted channel
//   Busy_Sig        - high whenever not idle
//
// Build option: UART_TX_ARB_CH_TAG_EN sends a tag byte (CH_TAG | channel)
// at the start of every grant so the receiver can demultiplex.
//
// state | meaning
// IDLE  | waiting for a requester, picks the round-robin winner
// HDR   | sending the channel tag byte (tag build only)
// RD    | read pulse to the granted FIFO is on the bus
// LATCH | FIFO data valid, capture into TX_Data
// TX    | TX_En_Sig high, waiting for TX_Done_Sig
// NEXT  | continue the burst or hand off to the next channel
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH-1:0]           Ch_En,
  input  logic [NUM_CH-1:0]           Empty_Sig,
  input  logic [NUM_CH*8-1:0]         FIFO_Read_Data,
  output logic [NUM_CH-1:0]           Read_Req_Sig,
  input  logic                        TX_Done_Sig,
  output logic [7:0]                  TX_Data,
  output logic                        TX_En_Sig,
  output logic [clog2w(NUM_CH)-1:0]   Grant_Ch,
  output logic                        Busy_Sig
);

  localparam int W  = clog2w(NUM_CH);
  localparam int BW = clog2w(MAX_BURST + 1);

  state_t              state;
  logic [W-1:0]        rr_ptr;
  logic [BW-1:0]       burst_cnt;
  logic [NUM_CH-1:0]   req;
  logic [W-1:0]        winner;
  logic                any_req;

  assign req = Ch_En & ~Empty_Sig;

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      burst_cnt    <= '0;
      Read_Req_Sig <= '0;
      TX_Data      <= 8'h00;
      TX_En_Sig    <= 1'b0;
      Grant_Ch     <= '0;
      Busy_Sig     <= 1'b0;
    end else begin
      Read_Req_Sig <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            Grant_Ch  <= winner;
            burst_cnt <= '0;
            Busy_Sig  <= 1'b1;
`ifdef UART_TX_ARB_CH_TAG_EN
            TX_Data   <= CH_TAG | 8'(winner);
            TX_En_Sig <= 1'b1;
            state     <= HDR;
`else
            Read_Req_Sig <= NUM_CH'(1) << winner;
            state        <= RD;
`endif
          end
        end
`ifdef UART_TX_ARB_CH_TAG_EN
        HDR: begin
          if (TX_Done_Sig) begin
            TX_En_Sig    <= 1'b0;
            Read_Req_Sig <= NUM_CH'(1) << Grant_Ch;
            state        <= RD;
          end
        end
`endif
        RD: state <= LATCH;
        LATCH: begin
          TX_Data   <= FIFO_Read_Data[{Grant_Ch, 3'b000} +: 8];
          TX_En_Sig <= 1'b1;
          state     <= TX;
        end
        TX: begin
          if (TX_Done_Sig) begin
            TX_En_Sig <= 1'b0;
            burst_cnt <= burst_cnt + BW'(1);
            state     <= NEXT;
          end
        end
        NEXT: begin
          if ((burst_cnt < BW'(MAX_BURST)) && req[Grant_Ch]) begin
            Read_Req_Sig <= NUM_CH'(1) << Grant_Ch;
            state        <= RD;
          end else begin
            rr_ptr   <= (Grant_Ch == W'(NUM_CH - 1)) ? '0 : Grant_Ch + W'(1);
            Busy_Sig <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          TX_En_Sig <= 1'b0;
          Busy_Sig  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_CH=4, MAX_BURST=4) with a FIFO
// model per channel and a UART model that pulses done 10 cycles after TX_En.
module tb_uart_tx_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  Ch_En;
  logic [3:0]  Empty_Sig;
  logic [31:0] FIFO_Read_Data;
  logic [3:0]  Read_Req_Sig;
  logic        TX_Done_Sig;
  logic [7:0]  TX_Data;
  logic        TX_En_Sig;
  logic [1:0]  Grant_Ch;
  logic        Busy_Sig;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(.NUM_CH(4), .MAX_BURST(4)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .Ch_En          (Ch_En),
    .Empty_Sig      (Empty_Sig),
    .FIFO_Read_Data (FIFO_Read_Data),
    .Read_Req_Sig   (Read_Req_Sig),
    .TX_Done_Sig    (TX_Done_Sig),
    .TX_Data        (TX_Data),
    .TX_En_Sig      (TX_En_Sig),
    .Grant_Ch       (Grant_Ch),
    .Busy_Sig       (Busy_Sig)
  );

  // bench-side models
  logic       tb_clr, ld_en, done_force, uart_done;
  int         ld_ch;
  logic [7:0] ld_dat;
  logic [7:0] mem [4][16];
  logic [3:0] wp [4];
  logic [3:0] rp [4];
  logic [7:0] rd_data [4];
  int         rd_cnt [4];
  int         bad_rd, consec, unstable, n_log, cyc, last_done, last_gap, ucnt;
  logic [3:0] rr_prev;
  logic       tx_en_prev;
  logic [7:0] txd_prev;
  logic [9:0] log_v [128];

  int         errors = 0;
  int         checks = 0;
  logic [9:0] exp_v [128];
  int         n_exp = 0;
  int         log_base = 0;

  always_comb begin
    Empty_Sig = '0;
    for (int n = 0; n < 4; n++) Empty_Sig[n] = (wp[n] == rp[n]);
  end
  assign FIFO_Read_Data = {rd_data[3], rd_data[2], rd_data[1], rd_data[0]};
  assign TX_Done_Sig    = uart_done | done_force;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (tb_clr) begin
      for (int n = 0; n < 4; n++) begin
        wp[n] <= '0; rp[n] <= '0; rd_data[n] <= '0; rd_cnt[n] <= 0;
      end
      bad_rd <= 0; consec <= 0; unstable <= 0; n_log <= 0;
      rr_prev <= '0; tx_en_prev <= 1'b0; txd_prev <= '0;
      last_done <= 0; last_gap <= 0;
    end else begin
      if (ld_en) begin
        mem[ld_ch][wp[ld_ch]] <= ld_dat;
        wp[ld_ch] <= wp[ld_ch] + 4'd1;
      end
      for (int n = 0; n < 4; n++) begin
        if (Read_Req_Sig[n]) begin
          rd_data[n] <= mem[n][rp[n]];
          rp[n]      <= rp[n] + 4'd1;
          rd_cnt[n]  <= rd_cnt[n] + 1;
          if (!Ch_En[n] || Empty_Sig[n]) bad_rd <= bad_rd + 1;
        end
      end
      if (|(Read_Req_Sig & rr_prev)) consec <= consec + 1;
      rr_prev <= Read_Req_Sig;
      if (TX_En_Sig && tx_en_prev && TX_Data != txd_prev) unstable <= unstable + 1;
      tx_en_prev <= TX_En_Sig;
      txd_prev   <= TX_Data;
      if (TX_En_Sig && TX_Done_Sig) begin
        log_v[n_log] <= {Grant_Ch, TX_Data};
        n_log        <= n_log + 1;
        last_done    <= cyc;
      end
      if (TX_En_Sig && !tx_en_prev) last_gap <= cyc - last_done;
    end
  end

  always @(posedge CLK) begin
    if (tb_clr || !TX_En_Sig || uart_done) begin
      ucnt <= 0; uart_done <= 1'b0;
    end else begin
      ucnt <= ucnt + 1;
      if (ucnt == 9) uart_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    if (obs != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int ch, input int d);
    ld_ch = ch; ld_dat = 8'(d); ld_en = 1'b1;
    @(negedge CLK);
    ld_en = 1'b0;
  endtask

  task automatic exp_b(input int ch, input int d);
    exp_v[n_exp] = 10'(ch * 256 + d);
    n_exp++;
  endtask

  task automatic exp_grant(input int ch);
`ifdef UART_TX_ARB_CH_TAG_EN
    exp_b(ch, 'hA0 + ch);
`else
    if (ch < 0) exp_b(ch, 0);
`endif
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge CLK);
    while ((Busy_Sig || (|(Ch_En & ~Empty_Sig))) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_idle"}, int'(n < 2000), 1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, n_log, n_exp);
    for (int i = log_base; i < n_exp; i++) chk(tag, int'(log_v[i]), int'(exp_v[i]));
    log_base = n_exp;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  int rd0, n, got;

  initial begin
    RST = 1'b1; tb_clr = 1'b1; Ch_En = '0; ld_en = 1'b0; ld_ch = 0; ld_dat = '0;
    done_force = 1'b0; cyc = 0;
    repeat (3) @(negedge CLK);
    tb_clr = 1'b0;
    chk("rst_read_req", int'(Read_Req_Sig), 0);
    chk("rst_tx_en",    int'(TX_En_Sig), 0);
    chk("rst_tx_data",  int'(TX_Data), 0);
    chk("rst_grant",    int'(Grant_Ch), 0);
    chk("rst_busy",     int'(Busy_Sig), 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // single channel with arbitration-to-TX timing
    push(1, 'h55); push(1, 'h3C);
    rd0 = rd_cnt[1];
    Ch_En = 4'hF;
    exp_grant(1); exp_b(1, 'h55); exp_b(1, 'h3C);
    @(negedge CLK);
    chk("t1_grant", int'(Grant_Ch), 1);
    chk("t1_busy",  int'(Busy_Sig), 1);
`ifndef UART_TX_ARB_CH_TAG_EN
    chk("t1_rdreq_c1", int'(Read_Req_Sig), 'b0010);
    @(negedge CLK);
    chk("t1_rdreq_c2", int'(Read_Req_Sig), 0);
    chk("t1_txen_c2",  int'(TX_En_Sig), 0);
    @(negedge CLK);
    chk("t1_txen_c3",  int'(TX_En_Sig), 1);
    chk("t1_txdat_c3", int'(TX_Data), 'h55);
`endif
    wait_idle("t1");
    check_log("t1_log");
    chk("t1_reads", rd_cnt[1] - rd0, 2);
    chk("t1_gap", last_gap, 4);

    // rr_ptr now 2: ch2 beats ch1
    Ch_En = '0;
    push(1, 'h91); push(2, 'hA2);
    Ch_En = 4'hF;
    exp_grant(2); exp_b(2, 'hA2); exp_grant(1); exp_b(1, 'h91);
    wait_idle("t1b");
    check_log("t1b_log");

    // fairness: 6 bytes per channel, bursts of 4 then 2
    do_reset();
    Ch_En = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 6; i++) push(c, c * 16 + i);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) begin
        exp_grant(c);
        for (int i = r * 4; i < ((r == 0) ? 4 : 6); i++) exp_b(c, c * 16 + i);
      end
    Ch_En = 4'hF;
    wait_idle("t2");
    check_log("t2_log");

    // wrap: grant ch2 alone (rr_ptr -> 3), then ch0 and ch2 requesting
    Ch_En = '0;
    push(2, 'h2A);
    Ch_En = 4'hF;
    exp_grant(2); exp_b(2, 'h2A);
    wait_idle("t3a");
    Ch_En = '0;
    push(0, 'h0B); push(2, 'h2B);
    Ch_En = 4'hF;
    exp_grant(0); exp_b(0, 'h0B); exp_grant(2); exp_b(2, 'h2B);
    wait_idle("t3");
    check_log("t3_log");

    // mask: ch2 pending but disabled
    Ch_En = 4'b1011;
    push(2, 'h5A);
    rd0 = rd_cnt[2];
    repeat (200) @(negedge CLK);
    chk("t4_masked_reads", rd_cnt[2] - rd0, 0);
    chk("t4_masked_busy", int'(Busy_Sig), 0);
    Ch_En = 4'hF;
    got = 0;
    repeat (2) begin
      @(negedge CLK);
      if (Busy_Sig && Grant_Ch == 2'd2) got = 1;
    end
    chk("t4_grant_2cyc", got, 1);
    exp_grant(2); exp_b(2, 'h5A);
    wait_idle("t4");
    check_log("t4_log");

    // reset mid-frame on ch3
    do_reset();
    Ch_En = '0;
    push(3, 'h77); push(3, 'h78);
    rd0 = rd_cnt[3];
    Ch_En = 4'hF;
    n = 0;
    while (!Read_Req_Sig[3] && n < 100) begin @(negedge CLK); n++; end
    while (!TX_En_Sig && n < 100) begin @(negedge CLK); n++; end
    chk("t5_reached_tx", int'(n < 100), 1);
    chk("t5_txdat", int'(TX_Data), 'h77);
    RST = 1'b1;
    @(negedge CLK);
    chk("t5_txen", int'(TX_En_Sig), 0);
    chk("t5_busy", int'(Busy_Sig), 0);
    chk("t5_grant", int'(Grant_Ch), 0);
    chk("t5_txdat_clr", int'(TX_Data), 0);
    Ch_En = '0;
    RST = 1'b0;
    @(negedge CLK);
    done_force = 1'b1;
    @(negedge CLK);
    done_force = 1'b0;
    @(negedge CLK);
    chk("t5_late_busy", int'(Busy_Sig), 0);
    chk("t5_late_txen", int'(TX_En_Sig), 0);
    chk("t5_late_log", n_log, n_exp);
    Ch_En = 4'hF;
    exp_grant(3); exp_b(3, 'h78);
    wait_idle("t5");
    check_log("t5_log");
    chk("t5_reads", rd_cnt[3] - rd0, 2);

    // ch3 single byte (tag byte first in the tag build)
    Ch_En = '0;
    push(3, 'h11);
    rd0 = rd_cnt[3];
    Ch_En = 4'hF;
    exp_grant(3); exp_b(3, 'h11);
    wait_idle("t6");
    check_log("t6_log");
    chk("t6_reads", rd_cnt[3] - rd0, 1);

    chk("bad_reads", bad_rd, 0);
    chk("consec_reads", consec, 0);
    chk("txdata_unstable", unstable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
